aes_decryptor_ip_buffer: RTL and testbench



---
 rtl/aes_decryptor_ip_buffer_pkg.sv | 28 ++
 rtl/aes_decryptor_ip_buffer_fifo.sv | 73 +++++++
 rtl/aes_decryptor_ip_buffer.sv | 107 ++++++++++
 tb/tb_aes_decryptor_ip_buffer.sv | 258 +++++++++++++++++++++++++
 4 files changed

// File: rtl/aes_decryptor_ip_buffer_pkg.sv
// Shared types, sizes and the byte placement rule for the AES block buffers.
package aes_buf_pkg;

  localparam int NO_ROWS_C = 4;
  localparam int NO_COLS_C = 4;
  localparam int BLK_BYTES = NO_ROWS_C * NO_COLS_C;
  localparam int BLK_BITS  = BLK_BYTES * 8;

  // Cipher-text state: state[row][col] is one byte.
  typedef logic [NO_ROWS_C-1:0][NO_COLS_C-1:0][7:0] aes_state_t;

  typedef struct packed {
    int row;
    int col;
  } rc_t;

  // Serial byte k goes to row rows-1-(k/cols), column cols-1-(k%cols):
  // the first byte lands in the top corner, the last in [0][0].
  function automatic rc_t byte_idx_to_rc(input int k,
                                         input int rows = NO_ROWS_C,
                                         input int cols = NO_COLS_C);
    rc_t rc;
    rc.row = rows - 1 - (k / cols);
    rc.col = cols - 1 - (k % cols);
    return rc;
  endfunction

endpackage

// File: rtl/aes_decryptor_ip_buffer_fifo.sv
// First-word-fall-through FIFO of whole cipher-text blocks.
module aes_blk_fifo
  import aes_buf_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int W     = $bits(aes_state_t)
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic                     pop,
  input  logic                     flush,
  input  logic [W-1:0]             din,
  output logic [W-1:0]             dout,
  output logic [$clog2(DEPTH):0]   level,
  output logic                     full,
  output logic                     empty
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [LW-1:0] level_q, level_d;
  logic          push_ok, pop_ok;

  assign full    = (level_q == LW'(DEPTH));
  assign empty   = (level_q == '0);
  assign level   = level_q;
  // A push into a full FIFO is only legal when the head leaves in the same cycle.
  assign push_ok = push && (!full || pop);
  assign pop_ok  = pop && !empty;
  // Empty FIFO presents zeros rather than stale RAM contents.
  assign dout    = empty ? '0 : mem[rd_ptr_q];

  // Pointer and level update; flush wins over any push/pop.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    level_d  = level_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      level_d  = '0;
    end else begin
      if (push_ok) wr_ptr_d = wr_ptr_q + AW'(1);
      if (pop_ok)  rd_ptr_d = rd_ptr_q + AW'(1);
      if (push_ok && !pop_ok)      level_d = level_q + LW'(1);
      else if (!push_ok && pop_ok) level_d = level_q - LW'(1);
    end
  end

  // Pointer and level registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
    end
  end

  // Block storage write port (no reset so it can map to RAM).
  always_ff @(posedge clk) begin
    if (push_ok && !flush) mem[wr_ptr_q] <= din;
  end

endmodule

// File: rtl/aes_decryptor_ip_buffer.sv
// Serial-to-block packer feeding a block FIFO toward the AES decryptor.
module aes_decryptor_ip_buffer
  import aes_buf_pkg::*;
#(
  parameter int BLK_DEPTH = 4,
  parameter int NO_ROWS   = 4,
  parameter int NO_COLS   = 4
) (
  input  logic                                   aes_clk,
  input  logic                                   reset,
  input  logic                                   ofdm_sdata_vld,
  output logic                                   ofdm_sdata_rdy,
  input  logic                                   ofdm_sdata,
  input  logic                                   flush,
  output logic                                   cipher_txt_vld,
  input  logic                                   cipher_txt_rdy,
  output logic [NO_ROWS-1:0][NO_COLS-1:0][7:0]   p_cipher_txt,
  output logic [$clog2(BLK_DEPTH):0]             blk_level
);

  localparam int NBYTES = NO_ROWS * NO_COLS;
  localparam int BW     = $clog2(NBYTES);
  localparam int W      = NBYTES * 8;
  localparam logic [BW-1:0] LAST_BYTE = BW'(NBYTES - 1);

  // Only 7 history bits are kept: the 8th bit completes the byte directly.
  logic [6:0]    sr_q, sr_d;
  logic [2:0]    bit_cnt_q, bit_cnt_d;
  logic [BW-1:0] byte_cnt_q, byte_cnt_d;
  logic [W-1:0]  staging_q, staging_d, staging_upd;
  logic [7:0]    byte_full;
  logic          accept, byte_done, blk_done;
  logic          fifo_full, fifo_empty, pop;
  logic [W-1:0]  fifo_dout;

  // Only the final bit of a block stalls when no block slot is free.
  assign ofdm_sdata_rdy = !reset &&
                          !(fifo_full && bit_cnt_q == 3'd7 && byte_cnt_q == LAST_BYTE);
  assign accept    = ofdm_sdata_vld && ofdm_sdata_rdy;
  assign byte_full = {sr_q, ofdm_sdata};
  assign byte_done = accept && (bit_cnt_q == 3'd7);
  assign blk_done  = byte_done && (byte_cnt_q == LAST_BYTE);

  // Each byte slot is rewritten only when its serial index completes.
  for (genvar gi = 0; gi < NBYTES; gi++) begin : g_place
    localparam rc_t RC  = byte_idx_to_rc(gi, NO_ROWS, NO_COLS);
    localparam int  OFS = 8 * (RC.row * NO_COLS + RC.col);
    assign staging_upd[OFS +: 8] = (byte_done && byte_cnt_q == BW'(gi)) ?
                                   byte_full : staging_q[OFS +: 8];
  end

  // Packer next state; flush drops the partial block and the presented bit.
  always_comb begin
    sr_d       = sr_q;
    bit_cnt_d  = bit_cnt_q;
    byte_cnt_d = byte_cnt_q;
    staging_d  = staging_q;
    if (flush) begin
      sr_d       = '0;
      bit_cnt_d  = '0;
      byte_cnt_d = '0;
      staging_d  = '0;
    end else if (accept) begin
      sr_d      = byte_full[6:0];
      bit_cnt_d = bit_cnt_q + 3'd1;
      staging_d = staging_upd;
      if (byte_done) byte_cnt_d = blk_done ? '0 : byte_cnt_q + BW'(1);
    end
  end

  // Packer registers.
  always_ff @(posedge aes_clk or posedge reset) begin
    if (reset) begin
      sr_q       <= '0;
      bit_cnt_q  <= '0;
      byte_cnt_q <= '0;
      staging_q  <= '0;
    end else begin
      sr_q       <= sr_d;
      bit_cnt_q  <= bit_cnt_d;
      byte_cnt_q <= byte_cnt_d;
      staging_q  <= staging_d;
    end
  end

  assign pop            = cipher_txt_vld && cipher_txt_rdy;
  assign cipher_txt_vld = !fifo_empty;
  assign p_cipher_txt   = fifo_dout;

  // The pushed block includes the byte completed on this same edge.
  aes_blk_fifo #(
    .DEPTH (BLK_DEPTH),
    .W     (W)
  ) u_fifo (
    .clk   (aes_clk),
    .rst   (reset),
    .push  (blk_done),
    .pop   (pop),
    .flush (flush),
    .din   (staging_upd),
    .dout  (fifo_dout),
    .level (blk_level),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

endmodule

// File: tb/tb_aes_decryptor_ip_buffer.sv
// Self-checking bench: directed table, multi-cycle corner sequences, random run.
module tb_aes_decryptor_ip_buffer;

  localparam int DEPTH = 4;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic sdata_vld = 1'b0;
  logic sdata = 1'b0;
  logic flush = 1'b0;
  logic crdy = 1'b0;
  logic sdata_rdy;
  logic cvld;
  logic [3:0][3:0][7:0] p;
  logic [2:0] level;

  always #5 clk = ~clk;

  aes_decryptor_ip_buffer #(
    .BLK_DEPTH (DEPTH),
    .NO_ROWS   (4),
    .NO_COLS   (4)
  ) dut (
    .aes_clk        (clk),
    .reset          (reset),
    .ofdm_sdata_vld (sdata_vld),
    .ofdm_sdata_rdy (sdata_rdy),
    .ofdm_sdata     (sdata),
    .flush          (flush),
    .cipher_txt_vld (cvld),
    .cipher_txt_rdy (crdy),
    .p_cipher_txt   (p),
    .blk_level      (level)
  );

  int checks = 0;
  int errors = 0;

  // Reference model: a queue of whole blocks, each the 128 received bits read
  // as one big-endian number, plus the partially received block.
  logic [127:0] mq[$];
  logic [127:0] mcur = '0;
  int           mbits = 0;
  logic         bitq[$];
  bit           macc;

  function automatic bit m_rdy();
    return !(mq.size() == DEPTH && mbits == 127);
  endfunction

  task automatic chk(input string name, input logic [127:0] got, input logic [127:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  task automatic m_clear();
    mq.delete();
    mcur  = '0;
    mbits = 0;
  endtask

  task automatic m_update();
    bit do_pop;
    macc = 1'b0;
    if (reset || flush) begin
      m_clear();
      return;
    end
    do_pop = (mq.size() != 0) && crdy;
    macc   = sdata_vld && m_rdy();
    if (do_pop) begin
      $display("pop  block %h", mq[0]);
      void'(mq.pop_front());
    end
    if (macc) begin
      mcur = {mcur[126:0], sdata};
      mbits++;
      if (mbits == 128) begin
        mq.push_back(mcur);
        $display("push block %h", mcur);
        mbits = 0;
      end
    end
  endtask

  task automatic check_all();
    logic [127:0] exp_data;
    exp_data = '0;
    if (mq.size() != 0) exp_data = mq[0];
    chk("rdy",   128'(sdata_rdy), 128'(!reset && m_rdy()));
    chk("vld",   128'(cvld),      128'(mq.size() != 0));
    chk("level", 128'(level),     128'(mq.size()));
    chk("data",  p,               exp_data);
  endtask

  // One clock: offer the next queued bit if allowed, update model, check.
  task automatic cycle(input bit offer);
    sdata_vld = offer && (bitq.size() != 0);
    sdata     = (bitq.size() != 0) ? bitq[0] : 1'b0;
    @(posedge clk);
    m_update();
    if (macc && bitq.size() != 0) void'(bitq.pop_front());
    @(negedge clk);
    check_all();
  endtask

  task automatic push_block(input logic [127:0] d);
    for (int i = 127; i >= 0; i--) bitq.push_back(d[i]);
  endtask

  function automatic logic [127:0] rand128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  task automatic send_all(input int bound);
    for (int i = 0; i < bound && bitq.size() != 0; i++) cycle(1'b1);
    chk("send_timeout", 128'(bitq.size()), 128'(0));
  endtask

  task automatic drain(input int bound);
    crdy = 1'b1;
    for (int i = 0; i < bound && (bitq.size() != 0 || mq.size() != 0 || mbits != 0); i++) begin
      if (bitq.size() == 0 && mbits != 0) bitq.push_back(1'($urandom));
      cycle(1'b1);
    end
    chk("drain_level", 128'(level), 128'(0));
  endtask

  typedef struct {
    logic [127:0] data;
    bit           gapped;
    int           exp_edges;
  } vec_t;

  vec_t tbl[4];

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int edges;
    bit seen;
    int thr;

    tbl[0] = '{128'h69c4e0d86a7b0430d8cdb78070b4c55a, 1'b0, 128};
    tbl[1] = '{128'h69c4e0d86a7b0430d8cdb78070b4c55a, 1'b1, 255};
    tbl[2] = '{128'h00112233445566778899aabbccddeeff, 1'b0, 128};
    tbl[3] = '{128'hfedcba98765432100123456789abcdef, 1'b1, 255};

    // Reset state.
    @(negedge clk);
    check_all();
    cycle(1'b0);
    reset = 1'b0;
    #1;
    chk("rdy_after_release", 128'(sdata_rdy), 128'(1));

    // Table: single blocks, gap-free and gapped, with latency and placement.
    foreach (tbl[t]) begin
      crdy  = 1'b1;
      push_block(tbl[t].data);
      edges = 0;
      seen  = 1'b0;
      for (int e = 1; e <= 400 && !seen; e++) begin
        cycle(!tbl[t].gapped || (e % 2 == 1));
        if (cvld) begin
          seen  = 1'b1;
          edges = e;
        end
      end
      chk("latency",  128'(edges),  128'(tbl[t].exp_edges));
      chk("byte_3_3", 128'(p[3][3]), 128'(tbl[t].data[127:120]));
      chk("byte_3_2", 128'(p[3][2]), 128'(tbl[t].data[119:112]));
      chk("byte_0_0", 128'(p[0][0]), 128'(tbl[t].data[7:0]));
      cycle(1'b1);
      chk("pulse_vld",   128'(cvld),  128'(0));
      chk("pulse_level", 128'(level), 128'(0));
    end

    // Fill: five blocks with the decryptor stalled; last bit of block 5 waits.
    crdy = 1'b0;
    for (int b = 0; b < 5; b++) push_block(rand128());
    for (int i = 0; i < 1000 && bitq.size() > 1; i++) cycle(1'b1);
    chk("full_rdy",   128'(sdata_rdy), 128'(0));
    chk("full_level", 128'(level),     128'(DEPTH));
    for (int i = 0; i < 3; i++) cycle(1'b1);
    chk("stall_rdy", 128'(sdata_rdy), 128'(0));
    // Pop while bit 127 is presented: rdy stays low that cycle.
    crdy = 1'b1;
    cycle(1'b1);
    chk("after_pop_level", 128'(level), 128'(DEPTH - 1));
    chk("after_pop_rdy",   128'(sdata_rdy), 128'(1));
    drain(1000);

    // Flush with two blocks queued and 37 bits of a third.
    crdy = 1'b0;
    push_block(rand128());
    push_block(rand128());
    for (int i = 0; i < 37; i++) bitq.push_back(1'($urandom));
    send_all(400);
    chk("pre_flush_level", 128'(level), 128'(2));
    flush = 1'b1;
    bitq.push_back(1'b1);
    cycle(1'b1);
    flush = 1'b0;
    bitq.delete();
    chk("flush_vld",   128'(cvld),  128'(0));
    chk("flush_level", 128'(level), 128'(0));
    push_block(rand128());
    drain(400);

    // Asynchronous reset mid-block and mid-handshake.
    crdy = 1'b0;
    push_block(rand128());
    for (int i = 0; i < 60; i++) bitq.push_back(1'($urandom));
    send_all(400);
    crdy = 1'b1;
    #2;
    reset = 1'b1;
    #1;
    chk("rst_vld",   128'(cvld),      128'(0));
    chk("rst_level", 128'(level),     128'(0));
    chk("rst_data",  p,               128'(0));
    chk("rst_rdy",   128'(sdata_rdy), 128'(0));
    m_clear();
    bitq.delete();
    @(negedge clk);
    cycle(1'b0);
    cycle(1'b0);
    reset = 1'b0;
    #1;
    chk("rdy_after_rst", 128'(sdata_rdy), 128'(1));
    push_block(128'h0f1e2d3c4b5a69788796a5b4c3d2e1f0);
    drain(400);

    // Randomised traffic with varying back-pressure and rare flushes.
    thr = 2;
    for (int i = 0; i < 3000; i++) begin
      if (i % 500 == 0) thr = $urandom_range(0, 4);
      crdy  = ($urandom_range(0, 3) < thr);
      flush = ($urandom_range(0, 299) == 0);
      if (bitq.size() == 0) bitq.push_back(1'($urandom));
      cycle($urandom_range(0, 3) != 0);
    end
    flush = 1'b0;
    drain(2000);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
